imem_loader: RTL and testbench

//   Write side of instruction memory: accepts a byte stream over valid/ready and writes it into

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: LEN byte, then 4*LEN data bytes written at ascending addresses.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err
);

  // state  | meaning
  // IDLE   | no session; waits for start (after reset or a rejected session)
  // GETLEN | waiting for the word-count byte
  // LOAD   | accepting data bytes; with count at zero it drains the final write
  // CSUM   | waiting for the checksum byte (checksum build only)
  // FIN    | one settle cycle so the last write commits
  // DONE   | image loaded, core released; start opens a new session

  localparam logic [8:0]        MAX_WORDS = 9'(MEM_BYTES / 4);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GETLEN, S_LOAD, S_CSUM, S_FIN, S_DONE
  } state_t;

  state_t            state;
  logic [9:0]        cnt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      err       <= 1'b0;
      cnt       <= '0;
      ptr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_GETLEN;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            ptr      <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_GETLEN: begin
          if (accept) begin
            if ({1'b0, rx_data} > MAX_WORDS) begin
              err      <= 1'b1;
              busy     <= 1'b0;
              rx_ready <= 1'b0;
              state    <= S_IDLE;
            end else if (rx_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_FIN;
              rx_ready <= 1'b0;
`endif
            end else begin
              state <= S_LOAD;
              cnt   <= {rx_data, 2'b00};
            end
          end
        end
        S_LOAD: begin
          // count reaching zero here means the last write is on the bus this cycle
          if (cnt == 10'd0) begin
            state <= S_FIN;
          end else if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= rx_data;
            ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
            cnt       <= cnt - 10'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= csum ^ rx_data;
            if (cnt == 10'd1) state <= S_CSUM;
`else
            if (cnt == 10'd1) rx_ready <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state <= S_FIN;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_FIN: begin
          state    <= S_DONE;
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          rx_ready <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 252) share one byte stream.
`timescale 1ns/1ps
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       a_rdy, a_we, a_busy, a_done, a_hold, a_err;
  logic [7:0] a_addr, a_wd;
  logic       b_rdy, b_we, b_busy, b_done, b_hold, b_err;
  logic [7:0] b_addr, b_wd;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .MEM_BYTES(256), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(a_rdy), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
    .busy(a_busy), .done(a_done), .cpu_hold(a_hold), .err(a_err));

  imem_loader #(.ADDR_W(8), .MEM_BYTES(256), .BASE_ADDR(252)) dut_hi (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(b_rdy), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .busy(b_busy), .done(b_done), .cpu_hold(b_hold), .err(b_err));

  int nchk = 0;
  int nerr = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  dat[256];

  typedef struct {
    logic [7:0] len;
    bit         gaps;
    bit         fixed;
    bit         exp_err;
    int         exp_nw;
  } vec_t;
  vec_t vecs[6];

  // every write strobe is one cycle wide, so one sample per low phase sees each once
  always @(negedge clk) begin
    if (a_we) qa.push_back({a_addr, a_wd});
    if (b_we) qb.push_back({b_addr, b_wd});
  end

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit   got;
    logic r;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      r = a_rdy;
      @(posedge clk);
      got = r;
    end
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (!got) check("accept_timeout", 0, 1);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xsum(input int nbytes);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < nbytes; i++) x ^= dat[i];
    return x;
  endfunction
`endif

  task automatic send_image(input int len, input bit gaps, input bit exp_err);
    send_byte(8'(len), gaps);
    if (!exp_err) begin
      for (int i = 0; i < 4 * len; i++) send_byte(dat[i], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(xsum(4 * len), gaps);
`endif
    end
  endtask

  task automatic check_writes(input string name, input int nw);
    int bad_a = 0;
    int bad_b = 0;
    check({name, "_cnt_a"}, qa.size(), nw);
    check({name, "_cnt_b"}, qb.size(), nw);
    for (int i = 0; i < qa.size() && i < nw; i++)
      if (qa[i] !== {8'(i % 256), dat[i]}) bad_a++;
    for (int i = 0; i < qb.size() && i < nw; i++)
      if (qb[i] !== {8'((252 + i) % 256), dat[i]}) bad_b++;
    check({name, "_data_a"}, bad_a, 0);
    check({name, "_data_b"}, bad_b, 0);
  endtask

  task automatic finish_session(input string name, input bit exp_err, input int exp_nw);
    for (int i = 0; i < 20 && !(a_done || a_err); i++) tick();
    check({name, "_done"}, a_done, exp_err ? 0 : 1);
    check({name, "_err"}, a_err, exp_err ? 1 : 0);
    check({name, "_hold"}, a_hold, exp_err ? 1 : 0);
    check({name, "_busy"}, a_busy, 0);
    check({name, "_rdy"}, a_rdy, 0);
    check({name, "_done_hi"}, b_done, exp_err ? 0 : 1);
    check_writes(name, exp_nw);
  endtask

  task automatic run_session(input string name, input int len, input bit gaps,
                             input bit exp_err, input int exp_nw);
    qa.delete();
    qb.delete();
    pulse_start();
    check({name, "_busy_on"}, a_busy, 1);
    check({name, "_rdy_on"}, a_rdy, 1);
    send_image(len, gaps, exp_err);
    finish_session(name, exp_err, exp_nw);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) dat[i] = 8'($urandom);
  endtask

  task automatic fill_fixed();
    logic [7:0] img [8] = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE2, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) dat[i] = img[i];
  endtask

  initial begin
    int len;
    bit e;

    // reset values while held in reset
    repeat (3) tick();
    check("rst_rdy", a_rdy, 0);
    check("rst_we", a_we, 0);
    check("rst_hold", a_hold, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_addr", a_addr, 0);
    reset_n = 1'b1;
    tick();

    // fixed image with rx_valid gaps; exact completion timing
    fill_fixed();
    qa.delete();
    qb.delete();
    pulse_start();
    send_byte(8'd2, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(dat[i], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum(8), 1'b1);
`else
    @(negedge clk);
    check("t2_last_we", a_we, 1);
    check("t2_last_addr", a_addr, 7);
    check("t2_done_t0", a_done, 0);
    @(negedge clk);
    check("t2_done_t1", a_done, 0);
    check("t2_hold_t1", a_hold, 1);
    @(negedge clk);
    check("t2_done_t2", a_done, 1);
    check("t2_hold_t2", a_hold, 0);
`endif
    finish_session("t2", 1'b0, 8);

    // oversize LEN is rejected on the following cycle
    qa.delete();
    qb.delete();
    pulse_start();
    send_byte(8'h41, 1'b0);
    @(negedge clk);
    check("t3_err", a_err, 1);
    check("t3_busy", a_busy, 0);
    check("t3_rdy", a_rdy, 0);
    check("t3_hold", a_hold, 1);
    repeat (3) tick();
    check("t3_no_we", qa.size(), 0);

    // asynchronous reset in the middle of a load
    fill_random();
    pulse_start();
    send_byte(8'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(dat[i], 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_async_we", a_we, 0);
    check("t4_async_rdy", a_rdy, 0);
    check("t4_async_hold", a_hold, 1);
    check("t4_async_busy", a_busy, 0);
    check("t4_async_addr", a_addr, 0);
    check("t4_async_wd", a_wd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    fill_random();
    run_session("t4", 1, 1'b0, 1'b0, 4);

    // start during LOAD is ignored
    fill_random();
    qa.delete();
    qb.delete();
    pulse_start();
    send_byte(8'd2, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(dat[i], 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_ign_busy", a_busy, 1);
    check("t5_ign_rdy", a_rdy, 1);
    for (int i = 3; i < 8; i++) send_byte(dat[i], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum(8), 1'b0);
`endif
    finish_session("t5a", 1'b0, 8);

    // start in DONE reopens a session; base-252 instance wraps
    fill_random();
    qa.delete();
    qb.delete();
    pulse_start();
    check("t5_restart_done", a_done, 0);
    check("t5_restart_hold", a_hold, 1);
    check("t5_restart_busy", a_busy, 1);
    send_image(2, 1'b1, 1'b0);
    finish_session("t5b", 1'b0, 8);

    vecs[0] = '{8'h02, 1'b1, 1'b1, 1'b0, 8};
    vecs[1] = '{8'h41, 1'b0, 1'b0, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{8'h40, 1'b0, 1'b0, 1'b0, 256};
    vecs[4] = '{8'h03, 1'b1, 1'b0, 1'b0, 12};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0};
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fixed) fill_fixed();
      else fill_random();
      run_session($sformatf("vec%0d", v), int'(vecs[v].len), vecs[v].gaps,
                  vecs[v].exp_err, vecs[v].exp_nw);
    end

    // random sessions judged by the length rule alone
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(0, 72));
      e   = (len > 256 / 4);
      fill_random();
      run_session($sformatf("rnd%0d_len%0d", r, len), len, 1'($urandom_range(0, 1)),
                  e, e ? 0 : 4 * len);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h04; dat[3] = 8'h08;
    qa.delete();
    qb.delete();
    pulse_start();
    send_byte(8'd1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(dat[i], 1'b0);
    send_byte(8'h0F, 1'b0);
    finish_session("t6_ok", 1'b0, 4);
    pulse_start();
    send_byte(8'd1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(dat[i], 1'b0);
    send_byte(8'h0E, 1'b0);
    @(negedge clk);
    check("t6_bad_err", a_err, 1);
    check("t6_bad_hold", a_hold, 1);
    check("t6_bad_done", a_done, 0);
    check("t6_bad_busy", a_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
